// File: rtl/lampfpu_log_postnorm.sv
// Post-normalisation stage of the LAMP FPU log unit: round-to-nearest-even, saturation and
// bfloat16 packing into a small output FIFO. Define LAMP_LOG_POSTNORM_STATS_EN for an inexact counter.
module lampfpu_log_postnorm #(
  parameter int FIFO_DEPTH = 2,
  parameter int GRS_DW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                s_res_i,
  input  logic [7:0]          e_res_i,
  input  logic [7+GRS_DW-1:0] f_res_i,
  input  logic                isOverflow_i,
  input  logic                isUnderflow_i,
  input  logic                isToRound_i,
  output logic                ready_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [15:0]         result_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic                inexact_o,
  output logic                drop_err_o
`ifdef LAMP_LOG_POSTNORM_STATS_EN
  ,
  output logic [15:0]         inexact_cnt_o
`endif
);

  localparam int E_DW  = 8;
  localparam int F_DW  = 7;
  localparam int FR_DW = F_DW + GRS_DW;
  localparam int ENT_W = 1 + E_DW + F_DW + 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // ---------------- rounding ----------------
  logic [F_DW-1:0] frac;
  logic            lsb, g_bit, r_bit, s_bit, up, grs;
  logic [F_DW:0]   sum;
  logic [E_DW:0]   e_sum;
  logic [E_DW-1:0] e_rnd;
  logic [F_DW-1:0] f_rnd;
  logic            ovf_rnd;

  always_comb begin
    frac    = f_res_i[FR_DW-1:GRS_DW];
    lsb     = f_res_i[GRS_DW];
    g_bit   = f_res_i[GRS_DW-1];
    r_bit   = f_res_i[GRS_DW-2];
    s_bit   = |f_res_i[GRS_DW-3:0];
    up      = g_bit & (r_bit | s_bit | lsb);
    sum     = {1'b0, frac} + {{F_DW{1'b0}}, up};
    e_sum   = {1'b0, e_res_i} + {{E_DW{1'b0}}, sum[F_DW]};
    e_rnd   = e_sum[E_DW-1:0];
    f_rnd   = sum[F_DW] ? '0 : sum[F_DW-1:0];
    // A carry out of 8'hFE, or an incoming 8'hFF, both land on the Inf encoding.
    ovf_rnd = e_sum[E_DW] | (&e_sum[E_DW-1:0]);
    grs     = g_bit | r_bit | s_bit;
  end

  logic [15:0] ent_res;
  logic        ent_ovf, ent_unf, ent_inx;

  always_comb begin
    ent_res = {s_res_i, e_rnd, f_rnd};
    ent_ovf = 1'b0;
    ent_unf = 1'b0;
    ent_inx = grs;
    if (!isToRound_i) begin
      ent_res = {s_res_i, e_res_i, frac};
      ent_inx = 1'b0;
    end else if (isOverflow_i) begin
      ent_res = {s_res_i, 8'hFF, 7'h00};
      ent_ovf = 1'b1;
      ent_inx = 1'b1;
    end else if (isUnderflow_i) begin
      ent_res = {s_res_i, 8'h00, 7'h00};
      ent_unf = 1'b1;
      ent_inx = 1'b1;
    end else if (ovf_rnd) begin
      ent_res = {s_res_i, 8'hFF, 7'h00};
      ent_ovf = 1'b1;
    end else if (e_rnd == '0 && f_rnd != '0) begin
      // No denormal output: flush to signed zero.
      ent_res = {s_res_i, 8'h00, 7'h00};
      ent_unf = 1'b1;
      ent_inx = 1'b1;
    end
  end

  // ---------------- output FIFO ----------------
  // Handshake: input is accepted when valid_i && ready_o at a rising edge (otherwise dropped);
  // the head is consumed when valid_o && ready_i at a rising edge. Outputs come only from registers.
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_err_q, drop_err_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign ready_o = (count_q < DEPTH_C);
  assign valid_o = (count_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    drop_err_d = drop_err_q | (valid_i & ~ready_o);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ent_res, ent_ovf, ent_unf, ent_inx};
  end

  // Gating with valid_o keeps stale storage off the bus after reset or drain.
  assign head        = valid_o ? mem_q[rd_ptr_q] : '0;
  assign result_o    = head[ENT_W-1:3];
  assign overflow_o  = head[2];
  assign underflow_o = head[1];
  assign inexact_o   = head[0];
  assign drop_err_o  = drop_err_q;

`ifdef LAMP_LOG_POSTNORM_STATS_EN
  logic [15:0] inexact_cnt_q, inexact_cnt_d;

  always_comb begin
    inexact_cnt_d = inexact_cnt_q;
    if (push && ent_inx && inexact_cnt_q != 16'hFFFF) inexact_cnt_d = inexact_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inexact_cnt_q <= '0;
    else     inexact_cnt_q <= inexact_cnt_d;
  end

  assign inexact_cnt_o = inexact_cnt_q;
`endif

endmodule

// File: tb/tb_lampfpu_log_postnorm.sv
// Directed bench for lampfpu_log_postnorm: rounding cases, overrides, FIFO backpressure and reset.
module tb_lampfpu_log_postnorm;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, s_res_i, isOverflow_i, isUnderflow_i, isToRound_i, ready_i;
  logic [7:0]  e_res_i;
  logic [9:0]  f_res_i;
  logic        ready_o, valid_o, overflow_o, underflow_o, inexact_o, drop_err_o;
  logic [15:0] result_o;
`ifdef LAMP_LOG_POSTNORM_STATS_EN
  logic [15:0] inexact_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  lampfpu_log_postnorm #(.FIFO_DEPTH(2), .GRS_DW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .s_res_i       (s_res_i),
    .e_res_i       (e_res_i),
    .f_res_i       (f_res_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .isToRound_i   (isToRound_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .inexact_o     (inexact_o),
    .drop_err_o    (drop_err_o)
`ifdef LAMP_LOG_POSTNORM_STATS_EN
    ,
    .inexact_cnt_o (inexact_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic s, input logic [7:0] e, input logic [9:0] f,
                        input logic ovf, input logic unf, input logic tr);
    valid_i       = 1'b1;
    s_res_i       = s;
    e_res_i       = e;
    f_res_i       = f;
    isOverflow_i  = ovf;
    isUnderflow_i = unf;
    isToRound_i   = tr;
  endtask

  task automatic idle();
    valid_i       = 1'b0;
    s_res_i       = 1'b0;
    e_res_i       = 8'h00;
    f_res_i       = 10'h000;
    isOverflow_i  = 1'b0;
    isUnderflow_i = 1'b0;
    isToRound_i   = 1'b1;
  endtask

  // Drive one vector for one edge; returns at the following negedge with the entry at the head.
  task automatic push_one(input logic s, input logic [7:0] e, input logic [9:0] f,
                          input logic ovf, input logic unf, input logic tr);
    @(negedge clk);
    set_in(s, e, f, ovf, unf, tr);
    @(negedge clk);
    idle();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    idle();
    ready_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    total++; if (result_o !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", result_o); end
    total++; if ({overflow_o, underflow_o, inexact_o, drop_err_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {overflow_o, underflow_o, inexact_o, drop_err_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_carry();
    push_one(1'b0, 8'h7E, 10'b1111111_100, 1'b0, 1'b0, 1'b1);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL carry_valid got=%b exp=1", valid_o); end
    total++; if (result_o !== 16'h3F80) begin bad++; $display("FAIL carry_result got=%h exp=3f80", result_o); end
    total++; if ({overflow_o, underflow_o, inexact_o} !== 3'b001) begin
      bad++; $display("FAIL carry_flags got=%b exp=001", {overflow_o, underflow_o, inexact_o});
    end
  endtask

  task automatic test_tie_even();
    push_one(1'b0, 8'h80, 10'b0010000_100, 1'b0, 1'b0, 1'b1);
    total++; if (result_o !== 16'h4010) begin bad++; $display("FAIL tie_even_result got=%h exp=4010", result_o); end
    total++; if (inexact_o !== 1'b1) begin bad++; $display("FAIL tie_even_inexact got=%b exp=1", inexact_o); end
    push_one(1'b0, 8'h80, 10'b0010001_100, 1'b0, 1'b0, 1'b1);
    total++; if (result_o !== 16'h4012) begin bad++; $display("FAIL tie_odd_result got=%h exp=4012", result_o); end
    // Above half and exact cases.
    push_one(1'b1, 8'h81, 10'b0000000_101, 1'b0, 1'b0, 1'b1);
    total++; if (result_o !== 16'hC081) begin bad++; $display("FAIL above_half_result got=%h exp=c081", result_o); end
    push_one(1'b0, 8'h7F, 10'b0000000_000, 1'b0, 1'b0, 1'b1);
    total++; if ({result_o, inexact_o} !== {16'h3F80, 1'b0}) begin
      bad++; $display("FAIL exact got=%h/%b exp=3f80/0", result_o, inexact_o);
    end
    push_one(1'b0, 8'h7F, 10'b0000000_011, 1'b0, 1'b0, 1'b1);
    total++; if ({result_o, inexact_o} !== {16'h3F80, 1'b1}) begin
      bad++; $display("FAIL below_half got=%h/%b exp=3f80/1", result_o, inexact_o);
    end
  endtask

  task automatic test_overflow();
    push_one(1'b0, 8'hFE, 10'b1111111_110, 1'b0, 1'b0, 1'b1);
    total++; if (result_o !== 16'h7F80) begin bad++; $display("FAIL round_ovf_result got=%h exp=7f80", result_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL round_ovf_flag got=%b exp=1", overflow_o); end
    push_one(1'b1, 8'h10, 10'b0000000_000, 1'b1, 1'b0, 1'b1);
    total++; if ({result_o, overflow_o, underflow_o, inexact_o} !== {16'hFF80, 3'b101}) begin
      bad++; $display("FAIL force_ovf got=%h/%b exp=ff80/101", result_o, {overflow_o, underflow_o, inexact_o});
    end
    // Overflow outranks underflow.
    push_one(1'b0, 8'h10, 10'b0000000_000, 1'b1, 1'b1, 1'b1);
    total++; if ({result_o, overflow_o, underflow_o} !== {16'h7F80, 2'b10}) begin
      bad++; $display("FAIL ovf_priority got=%h/%b exp=7f80/10", result_o, {overflow_o, underflow_o});
    end
  endtask

  task automatic test_underflow();
    push_one(1'b1, 8'h40, 10'b0101010_000, 1'b0, 1'b1, 1'b1);
    total++; if ({result_o, overflow_o, underflow_o, inexact_o} !== {16'h8000, 3'b011}) begin
      bad++; $display("FAIL force_unf got=%h/%b exp=8000/011", result_o, {overflow_o, underflow_o, inexact_o});
    end
    push_one(1'b0, 8'h00, 10'b0000101_000, 1'b0, 1'b0, 1'b1);
    total++; if ({result_o, underflow_o} !== {16'h0000, 1'b1}) begin
      bad++; $display("FAIL denorm_flush got=%h/%b exp=0000/1", result_o, underflow_o);
    end
  endtask

  task automatic test_special();
    push_one(1'b0, 8'hFF, 10'b1000000_111, 1'b0, 1'b0, 1'b0);
    total++; if (result_o !== 16'h7FC0) begin bad++; $display("FAIL special_result got=%h exp=7fc0", result_o); end
    total++; if ({overflow_o, underflow_o, inexact_o} !== 3'b000) begin
      bad++; $display("FAIL special_flags got=%b exp=000", {overflow_o, underflow_o, inexact_o});
    end
    // Passthrough ignores the override flags too.
    push_one(1'b1, 8'hFF, 10'b0000000_000, 1'b1, 1'b1, 1'b0);
    total++; if ({result_o, overflow_o, underflow_o, inexact_o} !== {16'hFF80, 3'b000}) begin
      bad++; $display("FAIL special_inf got=%h/%b exp=ff80/000", result_o, {overflow_o, underflow_o, inexact_o});
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ready_i = 1'b0;
    push_one(1'b0, 8'h80, 10'b0010000_000, 1'b0, 1'b0, 1'b1);   // A = 4010
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", ready_o); end
    push_one(1'b0, 8'h7F, 10'b0000000_000, 1'b0, 1'b0, 1'b1);   // B = 3f80
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", ready_o); end
    total++; if (drop_err_o !== 1'b0) begin bad++; $display("FAIL bp_drop_early got=%b exp=0", drop_err_o); end
    push_one(1'b0, 8'h90, 10'b1100000_000, 1'b0, 1'b0, 1'b1);   // C, dropped
    total++; if (drop_err_o !== 1'b1) begin bad++; $display("FAIL bp_drop_err got=%b exp=1", drop_err_o); end
    total++; if ({valid_o, result_o} !== {1'b1, 16'h4010}) begin
      bad++; $display("FAIL bp_head_a got=%b/%h exp=1/4010", valid_o, result_o);
    end
    ready_i = 1'b1;
    @(negedge clk);
    total++; if ({valid_o, result_o} !== {1'b1, 16'h3F80}) begin
      bad++; $display("FAIL bp_head_b got=%b/%h exp=1/3f80", valid_o, result_o);
    end
    @(negedge clk);
    total++; if ({valid_o, ready_o} !== 2'b01) begin
      bad++; $display("FAIL bp_drained got=%b exp=01", {valid_o, ready_o});
    end
    total++; if (drop_err_o !== 1'b1) begin bad++; $display("FAIL bp_drop_sticky got=%b exp=1", drop_err_o); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  vf [4];
    logic [15:0] vexp [4];
    vf[0] = 10'b0000001_000; vexp[0] = 16'h4001;
    vf[1] = 10'b0000001_100; vexp[1] = 16'h4002;
    vf[2] = 10'b0000010_100; vexp[2] = 16'h4002;
    vf[3] = 10'b1111111_111; vexp[3] = 16'h4080;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 8'h80, vf[i], 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      total++; if ({valid_o, ready_o, result_o} !== {2'b11, vexp[i]}) begin
        bad++; $display("FAIL b2b_%0d got=%b%b/%h exp=11/%h", i, valid_o, ready_o, result_o, vexp[i]);
      end
    end
    idle();
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", valid_o); end
    // Push and pop together with one entry held: count stays at one, order kept.
    ready_i = 1'b0;
    push_one(1'b0, 8'h81, 10'b0000000_000, 1'b0, 1'b0, 1'b1);   // X = 4080
    ready_i = 1'b1;
    set_in(1'b0, 8'h82, 10'b0000000_000, 1'b0, 1'b0, 1'b1);     // Y = 4100
    total++; if (result_o !== 16'h4080) begin bad++; $display("FAIL pp_head_x got=%h exp=4080", result_o); end
    @(negedge clk);
    idle();
    total++; if ({valid_o, ready_o, result_o} !== {2'b11, 16'h4100}) begin
      bad++; $display("FAIL pp_head_y got=%b%b/%h exp=11/4100", valid_o, ready_o, result_o);
    end
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", valid_o); end
  endtask

  task automatic test_reset_midop();
    ready_i = 1'b0;
    push_one(1'b0, 8'h80, 10'b0000011_000, 1'b0, 1'b0, 1'b1);
    push_one(1'b0, 8'h80, 10'b0000100_000, 1'b0, 1'b0, 1'b1);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rm_full got=%b exp=0", ready_o); end
    #2 rst = 1'b1;
    #1;
    total++; if ({valid_o, ready_o, drop_err_o, result_o} !== {3'b010, 16'h0000}) begin
      bad++; $display("FAIL rm_async got=%b%b%b/%h exp=010/0000", valid_o, ready_o, drop_err_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    set_in(1'b0, 8'h80, 10'b0000101_000, 1'b0, 1'b0, 1'b1);
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rm_no_early got=%b exp=0", valid_o); end
    @(negedge clk);
    idle();
    total++; if ({valid_o, result_o} !== {1'b1, 16'h4005}) begin
      bad++; $display("FAIL rm_after got=%b/%h exp=1/4005", valid_o, result_o);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_carry();
    test_tie_even();
    test_overflow();
    test_underflow();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef LAMP_LOG_POSTNORM_STATS_EN
    // Only the last push after reset was counted, and it is exact.
    total++; if (inexact_cnt_o !== 16'd0) begin bad++; $display("FAIL stats_cnt got=%0d exp=0", inexact_cnt_o); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lampfpu_log_postnorm.md
Name: lampfpu_log_postnorm

Overview:
- Downstream stage of the LAMP FPU log unit. Consumes its pre-rounding result: sign, exponent, fraction with 3 extra guard/round/sticky bits, and the special-case flags.
- Applies IEEE round-to-nearest-even, mantissa-overflow renormalisation, overflow/underflow saturation and inexact detection.
- Packs a bfloat16 word into an output FIFO with valid/ready handshake toward the FPU result bus.
- Isolates the non-stallable log unit from writeback backpressure.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; power of two, >=2.
- GRS_DW, 3, extra LSBs below the 7-bit fraction (guard, round, sticky).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  log result present this cycle.
- s_res_i  in  1  sign.
- e_res_i  in  LAMP_FLOAT_E_DW (8)  biased exponent.
- f_res_i  in  LAMP_FLOAT_F_DW+GRS_DW (10)  fraction[9:3], G[2], R[1], S[0].
- isOverflow_i  in  1  force ±Inf.
- isUnderflow_i  in  1  force ±0.
- isToRound_i  in  1  0 = special result (NaN/Inf), pass through unrounded.
- ready_o  out  1  space available in FIFO.
- valid_o  out  1  FIFO head valid.
- ready_i  in  1  consumer accepts head.
- result_o  out  16  {s,e[7:0],f[6:0]} of FIFO head.
- overflow_o, underflow_o, inexact_o  out  1 each  flags of FIFO head.
- drop_err_o  out  1  sticky: a valid_i arrived while ready_o=0.

Behaviour:
- Reset (async assert, sync deassert expected):
  - FIFO count=0, read/write pointers=0.
  - valid_o=0, result_o=0, all flags=0, drop_err_o=0, ready_o=1.
  - Any in-flight entries are discarded immediately.
- Push: valid_i && ready_o in cycle N. Rounded entry is written at the N edge. valid_o=1 from N+1 if FIFO was empty. Latency 1 cycle; throughput 1/cycle.
- Pop: valid_o && ready_i. Head advances at the edge. result_o is driven from the registered head only; no combinational path from valid_i.
- ready_o = (count < FIFO_DEPTH), decoded from registered count only.
  - When full, no push occurs even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: count is unchanged and order is preserved.
- Dropped input: valid_i && !ready_o:
  - Input is discarded and FIFO is unchanged.
  - drop_err_o sets next cycle and stays set until rst.
- Rounding, when isToRound_i=1 and neither override flag is set:
  - lsb=f[3], G=f[2], R=f[1], S=f[0].
  - up = G & (R | S | lsb).
  - {c,fr} = {1'b0,f[9:3]} + up.
  - If c=1: fr=0 and e=e_res_i+1.
  - If the result exponent reaches 8'hFF: result = {s,8'hFF,7'h00}, overflow=1.
  - inexact = G|R|S.
- Overrides, in priority order:
  1. isToRound_i=0: result = {s,e,f[9:3]} unchanged; all flags 0 (NaN/Inf payload preserved).
  2. isOverflow_i: {s,8'hFF,0}; overflow=1, inexact=1.
  3. isUnderflow_i: {s,8'h00,0}; underflow=1, inexact=1.
  4. Otherwise normal rounding.
- Denormals are not produced: exponent 0 with nonzero fraction is flushed to ±0 with underflow=1.
- Flags travel with their entry in the FIFO.

Optional Feature:
- Macro: LAMP_LOG_POSTNORM_STATS_EN.
- When defined:
  - Adds output port inexact_cnt_o, 16 bits.
  - Counter increments on every accepted push whose entry has inexact=1.
  - Saturates at 16'hFFFF; reset to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Carry into exponent: e=8'h7E, f=10'b1111111_100, ready_i=1 → next cycle valid_o=1, result_o=16'h3F80, inexact_o=1, overflow_o=0.
- Tie to even: e=8'h80, f=10'b0010000_100 → result_o=16'h4010 (no increment), inexact_o=1. Then f=10'b0010001_100 → result_o=16'h4012.
- Overflow:
  - e=8'hFE, f=10'b1111111_110 → result_o=16'h7F80, overflow_o=1.
  - isOverflow_i=1 with s=1 → result_o=16'hFF80.
- Special passthrough: isToRound_i=0, e=8'hFF, f=10'b1000000_111 → result_o=16'h7FC0, all flags 0.
- Backpressure:
  - ready_i=0; push A, B → ready_o=0.
  - Push C → drop_err_o=1, C lost.
  - ready_i=1 → A then B on consecutive cycles, then valid_o=0.
- Reset mid-op: FIFO holds 2 entries; pulse rst asynchronously between edges → valid_o=0 and ready_o=1 immediately. After release, a push yields valid_o one cycle later.
